pipeline_cfg_sync: RTL
======================

PIPELINE_CFG_SYNC -- requirements
Module: pipeline_cfg_sync

Interface
REQ-001 Parameter PRECISION, default 11: coordinate width; offsets are PRECISION+1 bits signed, clips are PRECISION bits.
REQ-002 Parameter TRANSPARENCY_PRECISION, default 3: opacity width is TRANSPARENCY_PRECISION+1 bits.
REQ-003 Port clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 Port wr_valid  input  1  decoded command write request from the SPI command decoder.
REQ-006 Port wr_ready  output  1  write accepted on any edge where wr_valid and wr_ready are both high.
REQ-007 Port wr_cmd  input  8  command code, using the existing SPI command map (0x00 reset, 0x01 mode, 0x03 scale, 0x04/0x05 offset X/Y, 0x06 opacity, 0x07-0x0A clip L/R/T/B, 0x0B freeze).
REQ-008 Port wr_arg  input  16  command argument, low bits used.
REQ-009 Port frame_start  input  1  one-cycle pulse from video timing at start of vertical blank.
REQ-010 Ports ctrl_fg_freeze(1), ctrl_overlay_mode(2), ctrl_fg_scale(2), ctrl_fg_offset_x/y(PRECISION+1), ctrl_fg_clip_left/right/top/bottom(PRECISION), ctrl_fg_opacity(TRANSPARENCY_PRECISION+1)  output  active configuration to pipeline.
REQ-011 Port cfg_pending  output  1  high while shadow differs from active due to accepted writes not yet committed.
REQ-012 Port cfg_committed  output  1  one-cycle pulse in the first cycle new active values are visible.

Function
REQ-013 Block SHALL hold a shadow copy of every ctrl_* field; accepted writes update shadow only.
REQ-014 FSM states SHALL be IDLE, PENDING, COMMIT.
REQ-015 IDLE: accepted write with recognised code -> PENDING; accepted write with unrecognised code (incl. 0x02, 0x0C, 0xFF) SHALL be consumed with no shadow change and no state change.
REQ-016 PENDING: frame_start high -> COMMIT; further writes keep updating shadow.
REQ-017 COMMIT: lasts exactly one cycle; on its closing edge active <= shadow, cfg_committed <= 1, state -> IDLE.
REQ-018 wr_ready SHALL be 1 in IDLE and PENDING, 0 in COMMIT.
REQ-019 Write accepted on the same edge frame_start is sampled in PENDING SHALL be included in that commit.
REQ-020 frame_start in IDLE or COMMIT SHALL be ignored.
REQ-021 Latency: frame_start sampled at edge k -> active outputs and cfg_committed change at edge k+1.
REQ-022 Field mapping: mode=arg[1:0], scale=arg[1:0], offsets=arg[PRECISION:0], clips=arg[PRECISION-1:0], opacity=arg[TRANSPARENCY_PRECISION:0], freeze=arg[0].
REQ-023 Command 0x00 SHALL load all shadow fields with reset values and set pending.
REQ-024 cfg_pending SHALL equal (state != IDLE).

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, cfg_committed 0, and both shadow and active to: freeze 0, mode 0, scale 0, offsets 0, clips 0, opacity all ones.
REQ-026 Reset during PENDING or COMMIT SHALL discard the pending commit; deassertion takes effect at the next edge.

Configuration
REQ-027 Macro PIPELINE_CFG_FRAME_SYNC_EN defined: commits gated by frame_start as above.
REQ-028 Macro undefined: PENDING -> COMMIT unconditionally on the next edge, frame_start ignored; accepted write at edge k is visible on outputs at edge k+2.

Structure
REQ-029 Package pipeline_cfg_pkg SHALL hold command code constants, FSM state encoding and field reset values, shared with the SPI command decoder.
REQ-030 Sub-module pipeline_cfg_decode SHALL map (wr_cmd, wr_arg) to per-field write enables and data; the FSM and both register banks stay in the top.

Verification
REQ-031 Reset release, no writes -> all outputs at reset values, opacity 4'hF, cfg_pending 0.
REQ-032 Write 0x04 arg 0x0123, no frame_start for 1000 cycles -> ctrl_fg_offset_x stays 0, cfg_pending 1; pulse frame_start -> offset_x 0x123 one edge later, cfg_committed one cycle.
REQ-033 Writes 0x01 arg 2 then 0x06 arg 5, then frame_start -> mode 2 and opacity 5 update on the same edge.
REQ-034 Write 0x07 arg 0x040 coincident with frame_start in PENDING -> clip_left 0x040 included in that commit; wr_ready low for the COMMIT cycle.
REQ-035 Write 0xFF or 0x0C -> accepted, cfg_pending stays 0; rst_n pulsed in COMMIT -> outputs at reset values, no cfg_committed.
REQ-036 Macro undefined: write 0x03 arg 1 at edge k -> ctrl_fg_scale 1 at edge k+2 with no frame_start.

Source files
------------

// File: rtl/pipeline_cfg_pkg.sv
// Command codes, FSM encoding, field indices and reset values for the pipeline configuration block.
// These are shared with the SPI command decoder.
package pipeline_cfg_pkg;

    localparam logic [7:0] CMD_RESET       = 8'h00;
    localparam logic [7:0] CMD_MODE        = 8'h01;
    localparam logic [7:0] CMD_SCALE       = 8'h03;
    localparam logic [7:0] CMD_OFFSET_X    = 8'h04;
    localparam logic [7:0] CMD_OFFSET_Y    = 8'h05;
    localparam logic [7:0] CMD_OPACITY     = 8'h06;
    localparam logic [7:0] CMD_CLIP_LEFT   = 8'h07;
    localparam logic [7:0] CMD_CLIP_RIGHT  = 8'h08;
    localparam logic [7:0] CMD_CLIP_TOP    = 8'h09;
    localparam logic [7:0] CMD_CLIP_BOTTOM = 8'h0A;
    localparam logic [7:0] CMD_FREEZE      = 8'h0B;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COMMIT  = 2'd2
    } cfg_state_t;

    // Bit positions in the per-field write-enable vector; the four clips follow
    // FLD_CLIP0 in left, right, top, bottom order.
    localparam int FLD_MODE     = 0;
    localparam int FLD_SCALE    = 1;
    localparam int FLD_OFFSET_X = 2;
    localparam int FLD_OFFSET_Y = 3;
    localparam int FLD_OPACITY  = 4;
    localparam int FLD_FREEZE   = 5;
    localparam int FLD_CLIP0    = 6;
    localparam int NUM_CLIPS    = 4;
    localparam int FLD_COUNT    = FLD_CLIP0 + NUM_CLIPS;

    // Wide reset values are sliced to the configured field widths by the user.
    localparam logic        RST_FREEZE  = 1'b0;
    localparam logic [1:0]  RST_MODE    = 2'd0;
    localparam logic [1:0]  RST_SCALE   = 2'd0;
    localparam logic [15:0] RST_OFFSET  = 16'h0000;
    localparam logic [15:0] RST_CLIP    = 16'h0000;
    localparam logic [15:0] RST_OPACITY = 16'hFFFF;

    function automatic logic cmd_is_known(input logic [7:0] cmd);
        return (cmd == CMD_RESET) || (cmd == CMD_MODE) ||
               ((cmd >= CMD_SCALE) && (cmd <= CMD_FREEZE));
    endfunction

endpackage

// File: rtl/pipeline_cfg_decode.sv
// Maps a command code and argument onto per-field write enables and field data.
// Unrecognised codes raise no enable, so the write is consumed without effect.
module pipeline_cfg_decode
    import pipeline_cfg_pkg::*;
#(
    parameter int PRECISION              = 11,
    parameter int TRANSPARENCY_PRECISION = 3
) (
    input  logic [7:0]                        cmd,
    input  logic [15:0]                       arg,
    output logic                              known,
    output logic                              load_defaults,
    output logic [FLD_COUNT-1:0]              field_we,
    output logic [1:0]                        mode_data,
    output logic [1:0]                        scale_data,
    output logic [PRECISION:0]                offset_data,
    output logic [PRECISION-1:0]              clip_data,
    output logic [TRANSPARENCY_PRECISION:0]   opacity_data,
    output logic                              freeze_data
);

    assign known         = cmd_is_known(cmd);
    assign load_defaults = (cmd == CMD_RESET);

    assign field_we[FLD_MODE]     = (cmd == CMD_MODE);
    assign field_we[FLD_SCALE]    = (cmd == CMD_SCALE);
    assign field_we[FLD_OFFSET_X] = (cmd == CMD_OFFSET_X);
    assign field_we[FLD_OFFSET_Y] = (cmd == CMD_OFFSET_Y);
    assign field_we[FLD_OPACITY]  = (cmd == CMD_OPACITY);
    assign field_we[FLD_FREEZE]   = (cmd == CMD_FREEZE);

    // Clip commands are consecutive codes starting at CMD_CLIP_LEFT.
    for (genvar gi = 0; gi < NUM_CLIPS; gi++) begin : g_clip_we
        assign field_we[FLD_CLIP0+gi] = (cmd == (CMD_CLIP_LEFT + 8'(gi)));
    end

    assign mode_data    = arg[1:0];
    assign scale_data   = arg[1:0];
    assign offset_data  = arg[PRECISION:0];
    assign clip_data    = arg[PRECISION-1:0];
    assign opacity_data = arg[TRANSPARENCY_PRECISION:0];
    assign freeze_data  = arg[0];

    logic unused_arg_bits;
    assign unused_arg_bits = ^arg[15:PRECISION+1];

endmodule

// File: rtl/pipeline_cfg_sync.sv
// Double-buffered pipeline configuration: writes land in a shadow bank, copied to the active bank in one cycle.
// PIPELINE_CFG_FRAME_SYNC_EN gates the copy on frame_start; without it the copy follows the first write at once.
module pipeline_cfg_sync
    import pipeline_cfg_pkg::*;
#(
    parameter int PRECISION              = 11,
    parameter int TRANSPARENCY_PRECISION = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [7:0]                        wr_cmd,
    input  logic [15:0]                       wr_arg,
    input  logic                              frame_start,
    output logic                              ctrl_fg_freeze,
    output logic [1:0]                        ctrl_overlay_mode,
    output logic [1:0]                        ctrl_fg_scale,
    output logic [PRECISION:0]                ctrl_fg_offset_x,
    output logic [PRECISION:0]                ctrl_fg_offset_y,
    output logic [PRECISION-1:0]              ctrl_fg_clip_left,
    output logic [PRECISION-1:0]              ctrl_fg_clip_right,
    output logic [PRECISION-1:0]              ctrl_fg_clip_top,
    output logic [PRECISION-1:0]              ctrl_fg_clip_bottom,
    output logic [TRANSPARENCY_PRECISION:0]   ctrl_fg_opacity,
    output logic                              cfg_pending,
    output logic                              cfg_committed
);

    cfg_state_t state_reg, state_next;
    logic       accept;
    logic       commit_now;

    logic                            known;
    logic                            load_defaults;
    logic [FLD_COUNT-1:0]            field_we;
    logic [1:0]                      mode_data, scale_data;
    logic [PRECISION:0]              offset_data;
    logic [PRECISION-1:0]            clip_data;
    logic [TRANSPARENCY_PRECISION:0] opacity_data;
    logic                            freeze_data;

    pipeline_cfg_decode #(
        .PRECISION              (PRECISION),
        .TRANSPARENCY_PRECISION (TRANSPARENCY_PRECISION)
    ) u_decode (
        .cmd           (wr_cmd),
        .arg           (wr_arg),
        .known         (known),
        .load_defaults (load_defaults),
        .field_we      (field_we),
        .mode_data     (mode_data),
        .scale_data    (scale_data),
        .offset_data   (offset_data),
        .clip_data     (clip_data),
        .opacity_data  (opacity_data),
        .freeze_data   (freeze_data)
    );

    assign accept = wr_valid && wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && known) begin
                    state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
`ifdef PIPELINE_CFG_FRAME_SYNC_EN
                if (frame_start) begin
                    state_next = ST_COMMIT;
                end
`else
                state_next = ST_COMMIT;
`endif
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

`ifndef PIPELINE_CFG_FRAME_SYNC_EN
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
`endif

    // Writes stall only in the single copy cycle so the shadow is stable while it is sampled.
    always_comb begin
        wr_ready    = 1'b1;
        cfg_pending = 1'b0;
        commit_now  = 1'b0;
        case (state_reg)
            ST_PENDING: cfg_pending = 1'b1;
            ST_COMMIT: begin
                wr_ready    = 1'b0;
                cfg_pending = 1'b1;
                commit_now  = 1'b1;
            end
            default: ;
        endcase
    end

    logic                            freeze_shadow_reg, freeze_active_reg;
    logic [1:0]                      mode_shadow_reg, mode_active_reg;
    logic [1:0]                      scale_shadow_reg, scale_active_reg;
    logic [PRECISION:0]              offset_x_shadow_reg, offset_x_active_reg;
    logic [PRECISION:0]              offset_y_shadow_reg, offset_y_active_reg;
    logic [TRANSPARENCY_PRECISION:0] opacity_shadow_reg, opacity_active_reg;
    logic                            committed_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freeze_shadow_reg   <= RST_FREEZE;
            mode_shadow_reg     <= RST_MODE;
            scale_shadow_reg    <= RST_SCALE;
            offset_x_shadow_reg <= RST_OFFSET[PRECISION:0];
            offset_y_shadow_reg <= RST_OFFSET[PRECISION:0];
            opacity_shadow_reg  <= RST_OPACITY[TRANSPARENCY_PRECISION:0];
        end else if (accept) begin
            if (load_defaults) begin
                freeze_shadow_reg   <= RST_FREEZE;
                mode_shadow_reg     <= RST_MODE;
                scale_shadow_reg    <= RST_SCALE;
                offset_x_shadow_reg <= RST_OFFSET[PRECISION:0];
                offset_y_shadow_reg <= RST_OFFSET[PRECISION:0];
                opacity_shadow_reg  <= RST_OPACITY[TRANSPARENCY_PRECISION:0];
            end else begin
                if (field_we[FLD_FREEZE])   freeze_shadow_reg   <= freeze_data;
                if (field_we[FLD_MODE])     mode_shadow_reg     <= mode_data;
                if (field_we[FLD_SCALE])    scale_shadow_reg    <= scale_data;
                if (field_we[FLD_OFFSET_X]) offset_x_shadow_reg <= offset_data;
                if (field_we[FLD_OFFSET_Y]) offset_y_shadow_reg <= offset_data;
                if (field_we[FLD_OPACITY])  opacity_shadow_reg  <= opacity_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freeze_active_reg   <= RST_FREEZE;
            mode_active_reg     <= RST_MODE;
            scale_active_reg    <= RST_SCALE;
            offset_x_active_reg <= RST_OFFSET[PRECISION:0];
            offset_y_active_reg <= RST_OFFSET[PRECISION:0];
            opacity_active_reg  <= RST_OPACITY[TRANSPARENCY_PRECISION:0];
            committed_reg       <= 1'b0;
        end else begin
            committed_reg <= commit_now;
            if (commit_now) begin
                freeze_active_reg   <= freeze_shadow_reg;
                mode_active_reg     <= mode_shadow_reg;
                scale_active_reg    <= scale_shadow_reg;
                offset_x_active_reg <= offset_x_shadow_reg;
                offset_y_active_reg <= offset_y_shadow_reg;
                opacity_active_reg  <= opacity_shadow_reg;
            end
        end
    end

    logic [PRECISION-1:0] clip_active [NUM_CLIPS];

    for (genvar gi = 0; gi < NUM_CLIPS; gi++) begin : g_clip
        logic [PRECISION-1:0] shadow_reg, active_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_reg <= RST_CLIP[PRECISION-1:0];
                active_reg <= RST_CLIP[PRECISION-1:0];
            end else begin
                if (accept && load_defaults) begin
                    shadow_reg <= RST_CLIP[PRECISION-1:0];
                end else if (accept && field_we[FLD_CLIP0+gi]) begin
                    shadow_reg <= clip_data;
                end
                if (commit_now) begin
                    active_reg <= shadow_reg;
                end
            end
        end

        assign clip_active[gi] = active_reg;
    end

    assign ctrl_fg_freeze      = freeze_active_reg;
    assign ctrl_overlay_mode   = mode_active_reg;
    assign ctrl_fg_scale       = scale_active_reg;
    assign ctrl_fg_offset_x    = offset_x_active_reg;
    assign ctrl_fg_offset_y    = offset_y_active_reg;
    assign ctrl_fg_opacity     = opacity_active_reg;
    assign ctrl_fg_clip_left   = clip_active[0];
    assign ctrl_fg_clip_right  = clip_active[1];
    assign ctrl_fg_clip_top    = clip_active[2];
    assign ctrl_fg_clip_bottom = clip_active[3];
    assign cfg_committed       = committed_reg;

endmodule
